// File: rtl/sum_control_unit.sv
// rtl/sum_control_unit.sv - control FSM and 8-bit adder computing sum(1..N) mod 256
// through an external 4x8 register file.
module sum_control_unit (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic [7:0] iLimit,
  input  logic [7:0] iRdData0,
  input  logic [7:0] iRdData1,
  output logic       oWrEn,
  output logic [1:0] oWrAddr,
  output logic [7:0] oWrData,
  output logic [1:0] oRdAddr0,
  output logic [1:0] oRdAddr1,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oSum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_I,
    S_INIT_S,
    S_INIT_ONE,
    S_CMP,
    S_INC,
    S_ADD,
    S_OUT
  } state_t;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R_I = 2'd1;
  localparam logic [1:0] R_SUM = 2'd2;
  localparam logic [1:0] R_ONE = 2'd3;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] rLimit;
  logic [7:0] alu_sum;

  // Carry is dropped on purpose so the running sum wraps mod 256.
  assign alu_sum = iRdData0 + iRdData1;
  assign oBusy   = (state != S_IDLE);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state  <= S_IDLE;
      rLimit <= 8'd0;
      oSum   <= 8'd0;
      oDone  <= 1'b0;
    end else begin
      state <= state_nxt;
      oDone <= (state == S_OUT);
      if (state == S_IDLE && iStart) begin
        rLimit <= iLimit;
      end
      if (state == S_OUT) begin
        oSum <= iRdData0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    oWrEn     = 1'b0;
    oWrAddr   = R0;
    oWrData   = 8'd0;
    oRdAddr0  = R0;
    oRdAddr1  = R0;
    case (state)
      S_IDLE: begin
        if (iStart) begin
          state_nxt = S_INIT_I;
        end
      end
      S_INIT_I: begin
        oWrEn     = 1'b1;
        oWrAddr   = R_I;
        oWrData   = alu_sum;
        state_nxt = S_INIT_S;
      end
      S_INIT_S: begin
        oWrEn     = 1'b1;
        oWrAddr   = R_SUM;
        oWrData   = alu_sum;
        state_nxt = S_INIT_ONE;
      end
      S_INIT_ONE: begin
        oWrEn     = 1'b1;
        oWrAddr   = R_ONE;
        oWrData   = 8'd1;
        state_nxt = S_CMP;
      end
      S_CMP: begin
        oRdAddr0  = R_I;
        state_nxt = (iRdData0 < rLimit) ? S_INC : S_OUT;
      end
      S_INC: begin
        oRdAddr0  = R_I;
        oRdAddr1  = R_ONE;
        oWrEn     = 1'b1;
        oWrAddr   = R_I;
        oWrData   = alu_sum;
        state_nxt = S_ADD;
      end
      S_ADD: begin
        oRdAddr0  = R_SUM;
        oRdAddr1  = R_I;
        oWrEn     = 1'b1;
        oWrAddr   = R_SUM;
        oWrData   = alu_sum;
        state_nxt = S_CMP;
      end
      S_OUT: begin
        oRdAddr0  = R_SUM;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sum_control_unit.sv
// tb/tb_sum_control_unit.sv - bench for sum_control_unit with a behavioural
// register file, vector table, scoreboard and multi-cycle corner sequences.
module tb_sum_control_unit;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic       iStart;
  logic [7:0] iLimit;
  logic [7:0] iRdData0;
  logic [7:0] iRdData1;
  logic       oWrEn;
  logic [1:0] oWrAddr;
  logic [7:0] oWrData;
  logic [1:0] oRdAddr0;
  logic [1:0] oRdAddr1;
  logic       oBusy;
  logic       oDone;
  logic [7:0] oSum;

  sum_control_unit dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iStart  (iStart),
    .iLimit  (iLimit),
    .iRdData0(iRdData0),
    .iRdData1(iRdData1),
    .oWrEn   (oWrEn),
    .oWrAddr (oWrAddr),
    .oWrData (oWrData),
    .oRdAddr0(oRdAddr0),
    .oRdAddr1(oRdAddr1),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oSum    (oSum)
  );

  always #5 iClk = ~iClk;

  // Register file: R0 reads as zero, combinational reads, write at the edge.
  logic [7:0] rf [4];
  always @(posedge iClk) if (oWrEn) rf[oWrAddr] <= oWrData;
  assign iRdData0 = (oRdAddr0 == 2'd0) ? 8'd0 : rf[oRdAddr0];
  assign iRdData1 = (oRdAddr1 == 2'd0) ? 8'd0 : rf[oRdAddr1];

  int checks = 0;
  int fails  = 0;
  int r0_writes = 0;
  int idle_port_bad = 0;
  int wide_done = 0;
  logic done_prev = 1'b0;
  logic [7:0] exp_q [$];

  always @(negedge iClk) begin
    if (oWrEn && oWrAddr == 2'd0) r0_writes++;
    if (!oWrEn && (oWrAddr != 2'd0 || oWrData != 8'd0)) idle_port_bad++;
    if (oDone && done_prev) wide_done++;
    done_prev = oDone;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Returns once the start edge has been taken; optionally records the expected sum.
  task automatic start_run(input logic [7:0] n, input logic [7:0] exp_sum, input bit push);
    @(posedge iClk);
    #1;
    iStart = 1'b1;
    iLimit = n;
    @(posedge iClk);
    if (push) exp_q.push_back(exp_sum);
    #1;
    iStart = 1'b0;
    iLimit = 8'($urandom_range(0, 255));
  endtask

  // Counts edges until oDone; pops the scoreboard and compares oSum there.
  task automatic wait_done(input int exp_lat, input bit disturb, input string name);
    int  k;
    bit  seen;
    logic [7:0] exp_sum;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 2000) begin
      @(posedge iClk);
      k++;
      @(negedge iClk);
      if (disturb) begin
        iStart = (k >= 4 && k <= 9);
        iLimit = 8'd3;
      end
      if (oDone) seen = 1'b1;
      else if (!oBusy) check({name, "_busy_dropped"}, k, -1);
    end
    if (disturb) iStart = 1'b0;
    if (!seen) begin
      check({name, "_timeout"}, k, exp_lat);
    end else begin
      check({name, "_latency"}, k, exp_lat);
      check({name, "_busy_at_done"}, int'(oBusy), 0);
      if (exp_q.size() == 0) begin
        check({name, "_scoreboard_empty"}, 0, 1);
      end else begin
        exp_sum = exp_q.pop_front();
        check({name, "_sum"}, int'(oSum), int'(exp_sum));
      end
    end
  endtask

  typedef struct {
    logic [7:0] limit;
    logic [7:0] sum;
    int         lat;
  } vec_t;

  initial begin
    vec_t vecs [6];
    vecs[0] = '{8'd10,  8'd55,  35};
    vecs[1] = '{8'd0,   8'd0,   5};
    vecs[2] = '{8'd23,  8'd20,  74};
    vecs[3] = '{8'd255, 8'd128, 770};
    vecs[4] = '{8'd1,   8'd1,   8};
    vecs[5] = '{8'd5,   8'd15,  20};

    iRst_n = 1'b0;
    iStart = 1'b0;
    iLimit = 8'd0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    check("rst_busy", int'(oBusy), 0);
    check("rst_done", int'(oDone), 0);
    check("rst_sum", int'(oSum), 0);
    check("rst_wren", int'(oWrEn), 0);
    check("rst_addrs", int'({oWrAddr, oRdAddr0, oRdAddr1}), 0);
    check("rst_wrdata", int'(oWrData), 0);
    #1 iRst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d_n%0d", i, vecs[i].limit);
      start_run(vecs[i].limit, vecs[i].sum, 1'b1);
      wait_done(vecs[i].lat, 1'b0, nm);
      check({nm, "_r1"}, int'(rf[1]), int'(vecs[i].limit));
      check({nm, "_r2"}, int'(rf[2]), int'(vecs[i].sum));
      check({nm, "_r3"}, int'(rf[3]), 1);
    end

    // Start pulses and a new limit during a run must not disturb it.
    start_run(8'd10, 8'd55, 1'b1);
    wait_done(35, 1'b1, "midrun_start");
    @(posedge iClk);
    @(negedge iClk);
    check("midrun_no_restart", int'(oBusy), 0);

    // Reset while the iteration-4 increment is being written.
    start_run(8'd10, 8'd0, 1'b0);
    repeat (13) @(posedge iClk);
    @(negedge iClk);
    check("pre_rst_busy", int'(oBusy), 1);
    check("pre_rst_wren", int'(oWrEn), 1);
    iRst_n = 1'b0;
    @(posedge iClk);
    @(negedge iClk);
    check("midrst_busy", int'(oBusy), 0);
    check("midrst_wren", int'(oWrEn), 0);
    check("midrst_sum", int'(oSum), 0);
    iRst_n = 1'b1;
    start_run(8'd5, 8'd15, 1'b1);
    wait_done(20, 1'b0, "after_rst_n5");

    // iStart held high: runs repeat every 12 cycles.
    @(posedge iClk);
    #1;
    iStart = 1'b1;
    iLimit = 8'd2;
    @(posedge iClk);
    exp_q.push_back(8'd3);
    wait_done(11, 1'b0, "b2b_run0");
    exp_q.push_back(8'd3);
    wait_done(12, 1'b0, "b2b_run1");
    exp_q.push_back(8'd3);
    @(posedge iClk);
    #1 iStart = 1'b0;
    wait_done(11, 1'b0, "b2b_run2");
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("b2b_stopped", int'(oBusy), 0);

    check("r0_writes", r0_writes, 0);
    check("idle_write_port_nonzero", idle_port_bad, 0);
    check("done_wider_than_1", wide_done, 0);
    check("scoreboard_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
